// File: rtl/axis_upsizer_8to32.sv
// AXI-Stream byte-to-word upsizer: packs 8-bit beats into 32-bit words with lane enables.
// Optional macro AXIS_UPSIZER_STATS_EN adds a 16-bit count of completed output frames.
module axis_upsizer_8to32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_t_data,
   input  logic        s_t_valid,
   input  logic        s_t_last,
   output logic        s_t_ready,
   output logic [31:0] m_t_data,
   output logic        m_t_valid,
   output logic        m_t_last,
   output logic [3:0]  m_byte_enable,
   input  logic        m_t_ready
`ifdef AXIS_UPSIZER_STATS_EN
   ,
   output logic [15:0] frame_count
`endif
);

   logic [1:0]       idx_reg;
   logic [2:0][7:0]  acc_reg;
   logic [31:0]      m_data_reg;
   logic             m_valid_reg;
   logic             m_last_reg;
   logic [3:0]       m_be_reg;

   logic [31:0]      word_next;
   logic [3:0]       be_next;
   logic             in_beat;
   logic             out_beat;
   logic             complete;

   assign s_t_ready = !m_valid_reg || m_t_ready;
   assign in_beat   = s_t_valid && s_t_ready;
   assign out_beat  = m_valid_reg && m_t_ready;
   assign complete  = in_beat && ((idx_reg == 2'd3) || s_t_last);

   // The incoming byte fills lane idx; lanes above it stay zero in a short final word.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         if (gi < 3) begin : g_acc
            assign word_next[gi*8 +: 8] = (LANE == idx_reg) ? s_t_data :
                                          (LANE <  idx_reg) ? acc_reg[gi] : 8'h00;
         end else begin : g_top
            assign word_next[gi*8 +: 8] = (LANE == idx_reg) ? s_t_data : 8'h00;
         end
         assign be_next[gi] = (LANE <= idx_reg);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg <= 2'd0;
         acc_reg <= '0;
      end else if (complete) begin
         idx_reg <= 2'd0;
         acc_reg <= '0;
      end else if (in_beat) begin
         acc_reg[idx_reg] <= s_t_data;
         idx_reg          <= idx_reg + 2'd1;
      end
   end

   // A completing beat can only be accepted when the output slot is free or draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data_reg  <= 32'h0;
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
         m_be_reg    <= 4'h0;
      end else if (complete) begin
         m_data_reg  <= word_next;
         m_valid_reg <= 1'b1;
         m_last_reg  <= s_t_last;
         m_be_reg    <= be_next;
      end else if (out_beat) begin
         m_valid_reg <= 1'b0;
      end
   end

   assign m_t_data      = m_data_reg;
   assign m_t_valid     = m_valid_reg;
   assign m_t_last      = m_last_reg;
   assign m_byte_enable = m_be_reg;

`ifdef AXIS_UPSIZER_STATS_EN
   logic [15:0] frame_count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_count_reg <= 16'h0;
      end else if (out_beat && m_last_reg) begin
         frame_count_reg <= frame_count_reg + 16'h1;
      end
   end

   assign frame_count = frame_count_reg;
`endif

endmodule

// File: tb/tb_axis_upsizer_8to32.sv
// Directed self-checking bench for axis_upsizer_8to32; inputs change and outputs are
// sampled on the falling clock edge.
module tb_axis_upsizer_8to32;

   logic        clk;
   logic        rst_n;
   logic [7:0]  s_t_data;
   logic        s_t_valid;
   logic        s_t_last;
   logic        s_t_ready;
   logic [31:0] m_t_data;
   logic        m_t_valid;
   logic        m_t_last;
   logic [3:0]  m_byte_enable;
   logic        m_t_ready;
`ifdef AXIS_UPSIZER_STATS_EN
   logic [15:0] frame_count;
`endif

   int checks;
   int errors;

   axis_upsizer_8to32 dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_t_data      (s_t_data),
      .s_t_valid     (s_t_valid),
      .s_t_last      (s_t_last),
      .s_t_ready     (s_t_ready),
      .m_t_data      (m_t_data),
      .m_t_valid     (m_t_valid),
      .m_t_last      (m_t_last),
      .m_byte_enable (m_byte_enable),
      .m_t_ready     (m_t_ready)
`ifdef AXIS_UPSIZER_STATS_EN
      ,
      .frame_count   (frame_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one input set for a full cycle, returning on the next falling edge.
   task automatic step(input logic [7:0] d, input logic v, input logic l);
      s_t_data  = d;
      s_t_valid = v;
      s_t_last  = l;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      m_t_ready = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (m_t_valid !== 1'b0 || m_t_data !== 32'h0 || m_t_last !== 1'b0 || m_byte_enable !== 4'h0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b data=%h last=%b be=%b want 0/00000000/0/0000",
                  m_t_valid, m_t_data, m_t_last, m_byte_enable);
      end
      checks++;
      if (s_t_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", s_t_ready);
      end
      rst_n = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (s_t_ready !== 1'b1 || m_t_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset: got ready=%b valid=%b want 1/0", s_t_ready, m_t_valid);
      end
      $display("test_reset done");
   endtask

   task automatic test_full_word;
      m_t_ready = 1'b1;
      step(8'h11, 1'b1, 1'b0);
      step(8'h22, 1'b1, 1'b0);
      step(8'h33, 1'b1, 1'b0);
      checks++;
      if (m_t_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_early: got valid=%b want 0", m_t_valid);
      end
      step(8'h44, 1'b1, 1'b1);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h44332211 || m_byte_enable !== 4'hF || m_t_last !== 1'b1) begin
         errors++;
         $display("FAIL full_word: got valid=%b data=%h be=%b last=%b want 1/44332211/1111/1",
                  m_t_valid, m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (m_t_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drain: got valid=%b want 0", m_t_valid);
      end
      $display("test_full_word word=44332211");
   endtask

   task automatic test_five_bytes;
      m_t_ready = 1'b1;
      step(8'h01, 1'b1, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      step(8'h03, 1'b1, 1'b0);
      step(8'h04, 1'b1, 1'b0);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h04030201 || m_byte_enable !== 4'hF || m_t_last !== 1'b0) begin
         errors++;
         $display("FAIL five_first: got valid=%b data=%h be=%b last=%b want 1/04030201/1111/0",
                  m_t_valid, m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h05, 1'b1, 1'b1);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h00000005 || m_byte_enable !== 4'h1 || m_t_last !== 1'b1) begin
         errors++;
         $display("FAIL five_tail: got valid=%b data=%h be=%b last=%b want 1/00000005/0001/1",
                  m_t_valid, m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h00, 1'b0, 1'b0);
      $display("test_five_bytes words=04030201,00000005");
   endtask

   task automatic test_single_byte;
      m_t_ready = 1'b1;
      step(8'hAB, 1'b1, 1'b1);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h000000AB || m_byte_enable !== 4'h1 || m_t_last !== 1'b1) begin
         errors++;
         $display("FAIL single: got valid=%b data=%h be=%b last=%b want 1/000000AB/0001/1",
                  m_t_valid, m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h00, 1'b0, 1'b0);
      $display("test_single_byte word=000000AB");
   endtask

   task automatic test_three_bytes;
      m_t_ready = 1'b1;
      step(8'hC1, 1'b1, 1'b0);
      step(8'hC2, 1'b1, 1'b0);
      step(8'hC3, 1'b1, 1'b1);
      checks++;
      if (m_t_data !== 32'h00C3C2C1 || m_byte_enable !== 4'h7 || m_t_last !== 1'b1) begin
         errors++;
         $display("FAIL three: got data=%h be=%b last=%b want 00C3C2C1/0111/1",
                  m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h00, 1'b0, 1'b0);
      $display("test_three_bytes word=00C3C2C1");
   endtask

   task automatic test_back_to_back;
      m_t_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_t_data  = 8'(8'h20 + i);
         s_t_valid = 1'b1;
         s_t_last  = (i == 7);
         #1;
         checks++;
         if (s_t_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready cycle %0d: got %b want 1", i, s_t_ready);
         end
         @(negedge clk);
         if (i == 3) begin
            checks++;
            if (m_t_data !== 32'h23222120 || m_t_valid !== 1'b1 || m_t_last !== 1'b0) begin
               errors++;
               $display("FAIL b2b_word0: got data=%h valid=%b last=%b want 23222120/1/0",
                        m_t_data, m_t_valid, m_t_last);
            end
         end
      end
      checks++;
      if (m_t_data !== 32'h27262524 || m_t_valid !== 1'b1 || m_t_last !== 1'b1 || m_byte_enable !== 4'hF) begin
         errors++;
         $display("FAIL b2b_word1: got data=%h valid=%b last=%b be=%b want 27262524/1/1/1111",
                  m_t_data, m_t_valid, m_t_last, m_byte_enable);
      end
      step(8'h00, 1'b0, 1'b0);
      $display("test_back_to_back words=23222120,27262524");
   endtask

   // Bytes 10..17 offered continuously; downstream stalls during cycles 4..7.
   task automatic test_stall;
      int  ptr;
      logic exp_rdy;
      ptr = 0;
      for (int c = 0; c < 12; c++) begin
         m_t_ready = !(c >= 4 && c <= 7);
         exp_rdy   = !(c >= 4 && c <= 7);
         s_t_valid = (ptr < 8);
         s_t_data  = 8'(8'h10 + ptr);
         s_t_last  = (ptr == 7);
         #1;
         checks++;
         if (s_t_ready !== exp_rdy) begin
            errors++;
            $display("FAIL stall_ready cycle %0d: got %b want %b", c, s_t_ready, exp_rdy);
         end
         if (c >= 4 && c <= 8) begin
            checks++;
            if (m_t_valid !== 1'b1 || m_t_data !== 32'h13121110 || m_t_last !== 1'b0 || m_byte_enable !== 4'hF) begin
               errors++;
               $display("FAIL stall_hold cycle %0d: got valid=%b data=%h last=%b be=%b want 1/13121110/0/1111",
                        c, m_t_valid, m_t_data, m_t_last, m_byte_enable);
            end
         end
         if (c == 9) begin
            checks++;
            if (m_t_valid !== 1'b0) begin
               errors++;
               $display("FAIL stall_drain: got valid=%b want 0", m_t_valid);
            end
         end
         @(negedge clk);
         if (exp_rdy && ptr < 8) ptr++;
      end
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h17161514 || m_t_last !== 1'b1 || m_byte_enable !== 4'hF) begin
         errors++;
         $display("FAIL stall_word1: got valid=%b data=%h last=%b be=%b want 1/17161514/1/1111",
                  m_t_valid, m_t_data, m_t_last, m_byte_enable);
      end
      m_t_ready = 1'b1;
      step(8'h00, 1'b0, 1'b0);
      $display("test_stall words=13121110,17161514");
   endtask

   task automatic test_reset_mid;
      // Pending word held by a stalled sink must vanish the moment reset asserts.
      m_t_ready = 1'b0;
      step(8'hE0, 1'b1, 1'b0);
      step(8'hE1, 1'b1, 1'b0);
      step(8'hE2, 1'b1, 1'b0);
      step(8'hE3, 1'b1, 1'b0);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'hE3E2E1E0) begin
         errors++;
         $display("FAIL rst_pending: got valid=%b data=%h want 1/E3E2E1E0", m_t_valid, m_t_data);
      end
      s_t_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (m_t_valid !== 1'b0 || m_t_data !== 32'h0 || m_t_last !== 1'b0 || m_byte_enable !== 4'h0 || s_t_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: got valid=%b data=%h last=%b be=%b ready=%b want 0/00000000/0/0000/1",
                  m_t_valid, m_t_data, m_t_last, m_byte_enable, s_t_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      m_t_ready = 1'b1;
      step(8'h55, 1'b1, 1'b0);
      step(8'h66, 1'b1, 1'b0);
      s_t_valid = 1'b0;
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(8'h77, 1'b1, 1'b1);
      checks++;
      if (m_t_valid !== 1'b1 || m_t_data !== 32'h00000077 || m_byte_enable !== 4'h1 || m_t_last !== 1'b1) begin
         errors++;
         $display("FAIL rst_lane0: got valid=%b data=%h be=%b last=%b want 1/00000077/0001/1",
                  m_t_valid, m_t_data, m_byte_enable, m_t_last);
      end
      step(8'h00, 1'b0, 1'b0);
      $display("test_reset_mid word=00000077");
   endtask

`ifdef AXIS_UPSIZER_STATS_EN
   task automatic test_stats;
      rst_n = 1'b0;
      step(8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      m_t_ready = 1'b1;
      for (int i = 0; i < 65537; i++) step(8'h5A, 1'b1, 1'b1);
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (frame_count !== 16'd1) begin
         errors++;
         $display("FAIL stats_wrap: got %0d want 1", frame_count);
      end
      $display("test_stats frame_count=%0d", frame_count);
   endtask
`endif

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      s_t_data  = 8'h00;
      s_t_valid = 1'b0;
      s_t_last  = 1'b0;
      m_t_ready = 1'b1;
      @(negedge clk);
      test_reset;
      test_full_word;
      test_five_bytes;
      test_single_byte;
      test_three_bytes;
      test_back_to_back;
      test_stall;
      test_reset_mid;
`ifdef AXIS_UPSIZER_STATS_EN
      test_stats;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_upsizer_8to32.md
AXIS_UPSIZER_8TO32 -- requirements
Module: axis_upsizer_8to32

Interface
REQ-001 Parameters: none; input width fixed 8 bits, output width fixed 32 bits, byte_enable 4 bits.
REQ-002 clk  input  1  single clock; all logic SHALL be rising-edge on clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_t_data  input  8  upstream byte.
REQ-005 s_t_valid  input  1  upstream byte valid.
REQ-006 s_t_last  input  1  upstream byte is final byte of frame.
REQ-007 s_t_ready  output  1  block accepts upstream byte this cycle.
REQ-008 m_t_data  output  32  packed word; byte i at bits [8i+7:8i].
REQ-009 m_t_valid  output  1  output word valid.
REQ-010 m_t_last  output  1  output word ends frame.
REQ-011 m_byte_enable  output  4  bit i set when byte i of m_t_data is valid.
REQ-012 m_t_ready  input  1  downstream accepts word.

Function
REQ-013 Input beat SHALL occur when s_t_valid && s_t_ready; output beat when m_t_valid && m_t_ready.
REQ-014 s_t_ready SHALL equal !m_t_valid || m_t_ready (combinational path m_t_ready->s_t_ready permitted; no path from s_t_valid).
REQ-015 Accumulator SHALL hold up to 4 bytes plus 2-bit byte index idx (0..3); accepted byte SHALL be written to lane idx.
REQ-016 A beat SHALL complete the word when idx==3 or s_t_last==1; otherwise idx SHALL increment.
REQ-017 On completing beat, the word SHALL load the output register on the same edge, m_t_valid SHALL rise next cycle (latency 1 cycle from completing byte), idx SHALL return to 0.
REQ-018 Unused lanes of a partial word SHALL be driven 0; m_byte_enable SHALL be 0001/0011/0111/1111 for 1/2/3/4 bytes.
REQ-019 Only a word with m_t_last==1 SHALL carry m_byte_enable != 1111.
REQ-020 m_t_last SHALL equal s_t_last of the completing byte.
REQ-021 Output register SHALL hold m_t_data, m_t_valid, m_t_last, m_byte_enable stable while m_t_valid && !m_t_ready.
REQ-022 Output beat with no completing beat same edge SHALL clear m_t_valid; simultaneous output beat and completing beat SHALL reload register with m_t_valid staying 1.
REQ-023 Sustained throughput SHALL be 1 byte/cycle when m_t_ready held 1.
REQ-024 Frame of 1 byte SHALL produce one word, byte_enable 0001, m_t_last 1.
REQ-025 Frame length multiple of 4 SHALL end on a full word with m_t_last 1; no empty trailing word SHALL be emitted.

Reset
REQ-026 rst_n low SHALL asynchronously clear idx, accumulator, m_t_data=0, m_t_valid=0, m_t_last=0, m_byte_enable=0.
REQ-027 Reset mid-frame SHALL discard partial word and pending output; first byte after reset SHALL land in lane 0.
REQ-028 s_t_ready SHALL be 1 during and immediately after reset (follows REQ-014 with m_t_valid=0).

Configuration
REQ-029 Macro AXIS_UPSIZER_STATS_EN defined: add output frame_count (16-bit), reset 0, increment on each output beat with m_t_last==1, wrap 0xFFFF->0x0000.
REQ-030 Macro undefined: frame_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-031 Bytes 11,22,33,44 (last on 44), m_t_ready=1 -> one word 0x44332211, byte_enable 1111, m_t_last 1, one cycle after byte 44.
REQ-032 Frame 5 bytes 01..05, m_t_ready=1 -> 0x04030201/1111/last 0, then 0x00000005/0001/last 1.
REQ-033 Continuous 8-byte frame, m_t_ready=0 during cycles 4-7 -> s_t_ready low only while word pending and blocked, no byte lost or duplicated, outputs stable while stalled.
REQ-034 Single-byte frame 0xAB -> 0x000000AB, byte_enable 0001, m_t_last 1.
REQ-035 rst_n pulsed low after 2 bytes of frame -> all outputs 0 immediately, next frame byte 0x77 appears in lane 0.
REQ-036 With AXIS_UPSIZER_STATS_EN, 65537 one-byte frames -> frame_count ends at 1 (wrap); without macro, elaboration has no frame_count port.
